// File: rtl/wash_cycle_timer.sv
// Washer/dryer cycle sequencer: steps FILL..DRY, counts each phase down in BCD M:SS
// and drives VALVE/MOTOR/HEATER. All outputs are registered from next-state values.
module wash_cycle_timer #(
   parameter int          TICKS_PER_SEC = 100000000,
   parameter logic [11:0] FILL_TIME     = 12'h030,
   parameter logic [11:0] WASH_TIME     = 12'h500,
   parameter logic [11:0] RINSE_TIME    = 12'h200,
   parameter logic [11:0] SPIN_TIME     = 12'h130,
   parameter logic [11:0] DRY_TIME      = 12'h900
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        START,
   input  logic        STOP,
   input  logic        PAUSE,
   input  logic        DRY_EN,
   output logic [12:0] VALUE,
   output logic [2:0]  PHASE,
   output logic        VALVE,
   output logic        MOTOR,
   output logic        HEATER,
   output logic        DONE
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_DRY   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   state_t        state, state_n;
   logic [11:0]   remaining, remaining_n;
   logic [PW-1:0] presc, presc_n;
   logic          paused, paused_n;
   logic          dry_sel, dry_sel_n;
   logic          active, counting, sec_tick;
   logic          active_n, run_n;

   // BCD decrement of M:S1S0; never called on 0:00 or 0:01
   function automatic logic [11:0] bcd_dec(input logic [11:0] t);
      logic [3:0] m, s1, s0;
      m  = t[11:8];
      s1 = t[7:4];
      s0 = t[3:0];
      if (s0 != 4'd0) begin
         s0 = s0 - 4'd1;
      end else begin
         s0 = 4'd9;
         if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
         end else begin
            s1 = 4'd5;
            m  = m - 4'd1;
         end
      end
      return {m, s1, s0};
   endfunction

   function automatic state_t next_phase(input state_t s, input logic dry);
      case (s)
         S_FILL:  return S_WASH;
         S_WASH:  return S_RINSE;
         S_RINSE: return S_SPIN;
         S_SPIN:  return dry ? S_DRY : S_DONE;
         default: return S_DONE;
      endcase
   endfunction

   function automatic logic [11:0] phase_time(input state_t s);
      case (s)
         S_FILL:  return FILL_TIME;
         S_WASH:  return WASH_TIME;
         S_RINSE: return RINSE_TIME;
         S_SPIN:  return SPIN_TIME;
         S_DRY:   return DRY_TIME;
         default: return 12'h000;
      endcase
   endfunction

   always_comb begin
      active      = (state != S_IDLE) && (state != S_DONE);
      counting    = active && !paused;
      sec_tick    = counting && (presc == PRESC_MAX);
      state_n     = state;
      remaining_n = remaining;
      presc_n     = presc;
      paused_n    = paused;
      dry_sel_n   = dry_sel;
      if (STOP) begin
         state_n     = S_IDLE;
         remaining_n = 12'h000;
         presc_n     = '0;
         paused_n    = 1'b0;
      end else if (START && !active) begin
         state_n     = S_FILL;
         remaining_n = FILL_TIME;
         presc_n     = '0;
         paused_n    = 1'b0;
         dry_sel_n   = DRY_EN;
      end else begin
         if (counting)
            presc_n = sec_tick ? '0 : presc + PW'(1);
         // The last second of a phase rolls straight into the next phase's duration
         if (sec_tick) begin
            if (remaining == 12'h001) begin
               state_n     = next_phase(state, dry_sel);
               remaining_n = phase_time(next_phase(state, dry_sel));
            end else begin
               remaining_n = bcd_dec(remaining);
            end
         end
         if (PAUSE && active)
            paused_n = !paused;
      end
      active_n = (state_n != S_IDLE) && (state_n != S_DONE);
      run_n    = active_n && !paused_n;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state     <= S_IDLE;
         remaining <= 12'h000;
         presc     <= '0;
         paused    <= 1'b0;
         dry_sel   <= 1'b0;
         VALUE     <= 13'h0000;
         PHASE     <= 3'd0;
         VALVE     <= 1'b0;
         MOTOR     <= 1'b0;
         HEATER    <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         presc     <= presc_n;
         paused    <= paused_n;
         dry_sel   <= dry_sel_n;
         VALUE     <= {run_n, remaining_n};
         PHASE     <= state_n;
         VALVE     <= run_n && (state_n == S_FILL || state_n == S_RINSE);
         MOTOR     <= run_n && (state_n == S_WASH || state_n == S_RINSE ||
                                state_n == S_SPIN || state_n == S_DRY);
         HEATER    <= run_n && (state_n == S_DRY);
         DONE      <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Bench for wash_cycle_timer: seconds-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized pulses.
module tb_wash_cycle_timer;

   localparam int TPS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, stop = 1'b0, pause = 1'b0, dry_en = 1'b0;
   logic [12:0] value;
   logic [2:0]  phase;
   logic        valve, motor, heater, done;

   int checks = 0;
   int failures = 0;

   // model state: phase number, remaining whole seconds, prescaler, pause, dry select
   int m_ph, m_rem, m_pr;
   bit m_pa, m_dr;

   always #5 clk = ~clk;

   wash_cycle_timer #(.TICKS_PER_SEC(TPS)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst_n),
      .START     (start),
      .STOP      (stop),
      .PAUSE     (pause),
      .DRY_EN    (dry_en),
      .VALUE     (value),
      .PHASE     (phase),
      .VALVE     (valve),
      .MOTOR     (motor),
      .HEATER    (heater),
      .DONE      (done)
   );

   function automatic int dur_s(input int ph);
      case (ph)
         1: return 30;
         2: return 300;
         3: return 120;
         4: return 90;
         5: return 540;
         default: return 0;
      endcase
   endfunction

   function automatic logic [11:0] to_bcd(input int s);
      logic [3:0] m, t, u;
      m = 4'(s / 60);
      t = 4'((s % 60) / 10);
      u = 4'(s % 10);
      return {m, t, u};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int ph, rem, pr;
      bit pa, dr, act, cnt, tick;
      if (!rst_n) begin
         m_ph <= 0; m_rem <= 0; m_pr <= 0; m_pa <= 1'b0; m_dr <= 1'b0;
      end else begin
         ph = m_ph; rem = m_rem; pr = m_pr; pa = m_pa; dr = m_dr;
         act = (ph >= 1 && ph <= 5);
         cnt = act && !pa;
         if (stop) begin
            ph = 0; rem = 0; pr = 0; pa = 1'b0;
         end else if (start && !act) begin
            ph = 1; rem = dur_s(1); pr = 0; pa = 1'b0; dr = dry_en;
         end else begin
            tick = cnt && (pr == TPS - 1);
            if (cnt) pr = tick ? 0 : pr + 1;
            if (tick) begin
               if (rem > 1) rem = rem - 1;
               else begin
                  if (ph == 4) ph = dr ? 5 : 6;
                  else if (ph == 5) ph = 6;
                  else ph = ph + 1;
                  rem = dur_s(ph);
               end
            end
            if (pause && act) pa = !pa;
         end
         m_ph <= ph; m_rem <= rem; m_pr <= pr; m_pa <= pa; m_dr <= dr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      bit run;
      logic [3:0] en;
      run = (m_ph >= 1 && m_ph <= 5) && !m_pa;
      case (m_ph)
         1: en = {3'b100, 1'b0};
         2: en = {3'b010, 1'b0};
         3: en = {3'b110, 1'b0};
         4: en = {3'b010, 1'b0};
         5: en = {3'b011, 1'b0};
         default: en = 4'b0000;
      endcase
      if (!run) en = 4'b0000;
      en[0] = (m_ph == 6);
      chk("model_value", {19'd0, value}, {19'd0, run, to_bcd(m_rem)});
      chk("model_phase", {29'd0, phase}, m_ph);
      chk("model_enables", {28'd0, valve, motor, heater, done}, {28'd0, en});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_phase(input int ph, input int maxc);
      int n = 0;
      while (phase != 3'(ph) && n < maxc) begin
         cyc();
         n++;
      end
      chk("wait_phase", {29'd0, phase}, ph);
   endtask

   initial begin
      // model pins
      chk("bcd_pin_299", {20'd0, to_bcd(299)}, 32'h459);
      chk("bcd_pin_70", {20'd0, to_bcd(70)}, 32'h110);

      #2;
      chk("reset_value", {19'd0, value}, 32'h0);
      chk("reset_phase_en", {26'd0, phase, valve, motor, heater}, 32'h0);
      cycn(2);
      rst_n = 1'b1;
      cycn(3);
      chk("idle_hold", {29'd0, phase}, 0);

      // basic run, no dry
      dry_en = 1'b0; start = 1'b1; cyc(); start = 1'b0;
      chk("start_value", {19'd0, value}, 32'h1030);
      chk("start_valve", {31'd0, valve}, 1);
      cycn(4);
      chk("first_tick", {19'd0, value}, 32'h1029);
      cycn(116);
      chk("wash_phase", {29'd0, phase}, 2);
      chk("wash_value", {19'd0, value}, 32'h1500);
      chk("wash_motor", {30'd0, motor, valve}, 32'h2);
      cycn(4);
      chk("borrow_500", {19'd0, value}, 32'h1459);
      wait_phase(6, 6000);
      chk("done_flags", {19'd0, value}, 32'h0);
      chk("done_out", {31'd0, done}, 1);
      pause = 1'b1; cyc(); pause = 1'b0;
      chk("pause_in_done", {29'd0, phase}, 6);

      // START in DONE restarts
      start = 1'b1; cyc(); start = 1'b0;
      chk("restart_fill", {19'd0, value}, 32'h1030);

      // DRY selected at START, DRY_EN dropped afterwards
      stop = 1'b1; cyc(); stop = 1'b0;
      dry_en = 1'b1; start = 1'b1; cyc(); start = 1'b0; dry_en = 1'b0;
      wait_phase(5, 6000);
      chk("dry_value", {19'd0, value}, 32'h1900);
      chk("dry_en", {30'd0, heater, motor}, 32'h3);

      // pause at WASH 3:27, hold 100 cycles, resume
      stop = 1'b1; cyc(); stop = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      for (int n = 0; n < 6000 && !(phase == 3'd2 && value[11:0] == 12'h327); n++) cyc();
      chk("reach_327", {20'd0, value[11:0]}, 32'h327);
      pause = 1'b1; cyc(); pause = 1'b0;
      chk("paused_value", {19'd0, value}, 32'h0327);
      chk("paused_en", {29'd0, valve, motor, heater}, 0);
      cycn(100);
      chk("paused_frozen", {19'd0, value}, 32'h0327);
      pause = 1'b1; cyc(); pause = 1'b0;
      cycn(8);

      // STOP and START together during RINSE
      wait_phase(3, 6000);
      stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
      chk("stop_start_phase", {29'd0, phase}, 0);
      chk("stop_start_value", {19'd0, value}, 32'h0);

      // asynchronous reset during SPIN
      start = 1'b1; cyc(); start = 1'b0;
      wait_phase(4, 6000);
      cycn(3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_value", {19'd0, value}, 32'h0);
      chk("async_rst_phase", {28'd0, phase, motor}, 0);
      cyc();
      rst_n = 1'b1;
      cycn(40);
      chk("post_rst_idle", {29'd0, phase}, 0);

      // randomized pulses
      for (int i = 0; i < 15000; i++) begin
         stop   = ($urandom % 600) == 0;
         start  = ($urandom % 150) == 0;
         pause  = ($urandom % 120) == 0;
         if (($urandom % 50) == 0) dry_en = ~dry_en;
         cyc();
      end
      stop = 1'b0; start = 1'b0; pause = 1'b0;
      cycn(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wash_cycle_timer.md
Name: wash_cycle_timer

Overview:
- Cycle sequencer and countdown timer for the washer/dryer model.
- Steps through FILL, WASH, RINSE, SPIN and an optional DRY phase, and drives the actuator enables.
- Counts down each phase's remaining time as three BCD digits (M:S1S0) on VALUE, which feeds the seven-segment display driver directly downstream.

Parameters:
- TICKS_PER_SEC, 100000000, CLK100MHZ cycles per one-second tick (set to 4 in simulation)
- FILL_TIME, 12'h030, FILL duration as BCD M,S1,S0 (0:30)
- WASH_TIME, 12'h500, WASH duration (5:00)
- RINSE_TIME, 12'h200, RINSE duration (2:00)
- SPIN_TIME, 12'h130, SPIN duration (1:30)
- DRY_TIME, 12'h900, DRY duration (9:00)

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- CPU_RESETN  input  1  asynchronous active-low reset
- START  input  1  one-cycle synchronous pulse (debounced upstream), starts a cycle
- STOP  input  1  one-cycle pulse, aborts the cycle
- PAUSE  input  1  one-cycle pulse, toggles pause while running
- DRY_EN  input  1  level, sampled at START; 1 = append DRY phase
- VALUE  output  13  [11:8]=minutes BCD, [7:4]=seconds tens BCD, [3:0]=seconds units BCD, [12]=counting (active phase and not paused)
- PHASE  output  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DRY, 6 DONE
- VALVE, MOTOR, HEATER  output  1 each  actuator enables
- DONE  output  1  high in DONE state

Behaviour:
- Reset (asynchronous on CPU_RESETN low; release is synchronous to CLK100MHZ):
  - State IDLE, VALUE=13'h0000, PHASE=0, all enables 0, DONE=0.
  - Prescaler 0, paused=0, dry_sel=0.
  - Reset mid-cycle aborts immediately. There is no resume.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only while counting=1.
  - sec_tick is asserted for one cycle when the count equals TICKS_PER_SEC-1, and the count then wraps to 0.
  - Held (not cleared) while paused. Cleared on START and STOP.
- START in IDLE or DONE:
  - Next cycle: state FILL, remaining=FILL_TIME, dry_sel=DRY_EN, prescaler=0, paused=0.
  - Ignored in any active phase.
- Countdown, on sec_tick:
  - If remaining != 0:01, decrement in BCD. Units borrow 0->9 into tens. Tens borrow 0->5 into minutes. Example: 5:00 -> 4:59, 1:10 -> 1:09.
  - If remaining == 0:01, advance to the next phase and load its duration in the same cycle.
  - A phase of duration D therefore lasts exactly D*TICKS_PER_SEC cycles while counting. The display shows D down to 0:01 and never shows 0:00 in an active phase.
- Phase sequence: FILL->WASH->RINSE->SPIN->(DRY if dry_sel)->DONE.
  - DONE: remaining=0:00, DONE=1, all enables 0.
  - DONE persists until START or STOP.
- STOP in any state: next cycle IDLE, remaining=0:00, paused=0, enables 0, DONE=0.
- PAUSE in an active phase toggles paused.
  - Paused: remaining and prescaler frozen, all enables 0, VALUE[12]=0. PHASE is unchanged.
  - PAUSE in IDLE or DONE is ignored.
- Simultaneous pulses:
  - STOP has priority over START and PAUSE.
  - START together with PAUSE in IDLE or DONE: START taken, PAUSE ignored.
  - PAUSE coincident with sec_tick: the tick is applied first, then paused is set. The tick is not lost.
- Enables by phase: FILL VALVE=1; WASH MOTOR=1; RINSE VALVE=1, MOTOR=1; SPIN MOTOR=1; DRY MOTOR=1, HEATER=1. All other states 0.
- All outputs are registered. Outputs change one cycle after the causing input pulse or sec_tick.
- Duration parameters must be valid BCD: S1<=5, and not 0:00. Behaviour with illegal parameters is undefined.
- VALUE[12]=1 iff state is FILL..DRY and paused=0.

Test Plan:
- TICKS_PER_SEC=4, DRY_EN=0, START pulse -> next cycle PHASE=1, VALUE=13'h1030, VALVE=1. After 4 cycles VALUE=13'h1029. After 30*4 cycles PHASE=2, VALUE=13'h1500, MOTOR=1. Full run ends in PHASE=6, DONE=1, VALUE=13'h0000.
- BCD borrow: run WASH to 5:00 then one tick -> 4:59. At 1:10 one tick -> 1:09. At 0:10 one tick -> 0:09. Minutes never underflow.
- DRY_EN=1 at START, DRY_EN dropped to 0 mid-cycle -> after SPIN 0:01 the next PHASE=5, VALUE=13'h1900, HEATER=1, MOTOR=1.
- PAUSE at WASH 3:27 with prescaler=2 -> VALUE=13'h0327, enables 0, value frozen for 100 cycles. Second PAUSE -> resumes, reaches 3:26 exactly 2 cycles later.
- STOP and START in the same cycle during RINSE -> IDLE, VALUE=0. START in DONE -> new cycle at FILL 0:30.
- CPU_RESETN asserted low during SPIN, asynchronously and mid-cycle -> outputs go to reset values without waiting for a clock edge. Timer stays in IDLE after release until START.
